// File: rtl/diaosi_types_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and
// the saturating stall-counter helper.
package diaosi_types_pkg;

    typedef enum logic [1:0] {
        HZ_RUN     = 2'd0,
        HZ_LDSTALL = 2'd1,
        HZ_DWAIT   = 2'd2,
        HZ_IMISS   = 2'd3
    } hz_state_t;

    localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        if (v == STALL_CNT_MAX) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

endpackage

// File: rtl/hz_scoreboard.sv
// In-flight writer tracker for stages EX..WB. Entry 0 sits behind the ID/EX
// latch; each entry advances when the latch feeding it is enabled.
module hz_scoreboard #(
    parameter int NSTAGE     = 5,
    parameter int REGW       = 5,
    parameter int LD_BUBBLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-3:0] i_latch_en,
    input  logic [NSTAGE-3:0] i_flush,
    input  logic [REGW-1:0]   i_id_rs,
    input  logic [REGW-1:0]   i_id_rt,
    input  logic              i_id_rs_use,
    input  logic              i_id_rt_use,
    input  logic              i_id_wen,
    input  logic [REGW-1:0]   i_id_wsel,
    input  logic              i_id_is_load,
    output logic              o_ld_hit,
    output logic              o_any_hit
);

    localparam int NENT = NSTAGE - 2;

    logic [NENT-1:0] r_valid;
    logic [NENT-1:0] r_is_load;
    logic [REGW-1:0] r_wsel [NENT];

    logic w_ld_hit;
    logic w_any_hit;

    // Shift register: bit k of the latch/flush slices is the latch in front of entry k
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= '0;
            r_is_load <= '0;
            for (int i = 0; i < NENT; i++) begin
                r_wsel[i] <= '0;
            end
        end else begin
            if (i_latch_en[0]) begin
                r_valid[0]   <= i_id_wen & ~i_flush[0];
                r_is_load[0] <= i_id_is_load & ~i_flush[0];
                r_wsel[0]    <= i_id_wsel;
            end
            for (int i = 1; i < NENT; i++) begin
                if (i_latch_en[i]) begin
                    r_valid[i]   <= r_valid[i-1] & ~i_flush[i];
                    r_is_load[i] <= r_is_load[i-1] & ~i_flush[i];
                    r_wsel[i]    <= r_wsel[i-1];
                end
            end
        end
    end

    // Source match; a zero wsel never matches, so register 0 cannot cause a hazard
    always_comb begin
        w_ld_hit  = 1'b0;
        w_any_hit = 1'b0;
        for (int i = 0; i < NENT; i++) begin
            if (r_valid[i] && (r_wsel[i] != '0) &&
                ((i_id_rs_use && (i_id_rs == r_wsel[i])) ||
                 (i_id_rt_use && (i_id_rt == r_wsel[i])))) begin
                w_any_hit = 1'b1;
                if (r_is_load[i] && (i < LD_BUBBLES)) begin
                    w_ld_hit = 1'b1;
                end else begin
                    w_ld_hit = w_ld_hit;
                end
            end else begin
                w_any_hit = w_any_hit;
            end
        end
    end

    assign o_ld_hit  = w_ld_hit;
    assign o_any_hit = w_any_hit;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: picks one stall/flush action per cycle by fixed
// priority and drives PC and inter-stage latch enables accordingly.
module hazard_ctrl
    import diaosi_types_pkg::*;
#(
    parameter int NSTAGE     = 5,
    parameter int REGW       = 5,
    parameter int LD_BUBBLES = 1,
    parameter int FWD_EN     = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              dmem_req,
    input  logic              dhit,
    input  logic [REGW-1:0]   id_rs,
    input  logic [REGW-1:0]   id_rt,
    input  logic              id_rs_use,
    input  logic              id_rt_use,
    input  logic              id_wen,
    input  logic [REGW-1:0]   id_wsel,
    input  logic              id_is_load,
    input  logic              ex_redirect,
    output logic              pc_en,
    output logic [NSTAGE-2:0] latch_en,
    output logic [NSTAGE-2:0] flush,
    output logic [1:0]        hz_state,
    output logic [31:0]       stall_cnt
);

    hz_state_t r_state;
    hz_state_t w_next;
    logic [31:0] r_stall_cnt;

    logic              w_pc_en;
    logic [NSTAGE-2:0] w_latch_en;
    logic [NSTAGE-2:0] w_flush;
    logic              w_dwait;
    logic              w_ld_hit;
    logic              w_any_hit;
    logic              w_lduse;

    hz_scoreboard #(
        .NSTAGE     (NSTAGE),
        .REGW       (REGW),
        .LD_BUBBLES (LD_BUBBLES)
    ) u_scoreboard (
        .clk          (CLK),
        .rst          (RST),
        .i_latch_en   (w_latch_en[NSTAGE-2:1]),
        .i_flush      (w_flush[NSTAGE-2:1]),
        .i_id_rs      (id_rs),
        .i_id_rt      (id_rt),
        .i_id_rs_use  (id_rs_use),
        .i_id_rt_use  (id_rt_use),
        .i_id_wen     (id_wen),
        .i_id_wsel    (id_wsel),
        .i_id_is_load (id_is_load),
        .o_ld_hit     (w_ld_hit),
        .o_any_hit    (w_any_hit)
    );

    // Without forwarding any in-flight writer of a used source must drain first
    assign w_lduse = (FWD_EN != 0) ? w_ld_hit : w_any_hit;
    assign w_dwait = dmem_req & ~dhit;

    // Priority: data wait > redirect > load-use > icache miss > run
    always_comb begin
        w_next     = HZ_RUN;
        w_pc_en    = 1'b1;
        w_latch_en = '1;
        w_flush    = '0;
        if (RST) begin
            w_flush = '1;
        end else if (w_dwait) begin
            w_next     = HZ_DWAIT;
            w_pc_en    = 1'b0;
            w_latch_en = '0;
        end else if (ex_redirect) begin
            w_flush[0] = 1'b1;
            w_flush[1] = 1'b1;
        end else if (w_lduse) begin
            w_next        = HZ_LDSTALL;
            w_pc_en       = 1'b0;
            w_latch_en[0] = 1'b0;
            w_flush[1]    = 1'b1;
        end else if (!ihit) begin
            w_next     = HZ_IMISS;
            w_pc_en    = 1'b0;
            w_flush[0] = 1'b1;
        end else begin
            w_next = HZ_RUN;
        end
    end

    // State register; records the action taken in the cycle just ended
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= HZ_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // Counts cycles whose recorded state is a stall, so it tracks hz_state
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= 32'd0;
        end else if (w_next != HZ_RUN) begin
            r_stall_cnt <= sat_inc32(r_stall_cnt);
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign pc_en     = w_pc_en;
    assign latch_en  = w_latch_en;
    assign flush     = w_flush;
    assign hz_state  = r_state;
    assign stall_cnt = r_stall_cnt;

endmodule
